vector_load_unit: RTL

- Fills the 8-entry x 256-bit vector register file from scalar data memory; it drives the file's write port (VwrEn/VwrAddr/Vwrdata).
- On a load command it issues 16 sequential 16-bit memory reads and packs the returned halfwords into one 256-bit vector. It then writes the vector into the destination vector register in a single cycle.
- Sits between the vector instruction decoder and the vector register file.

---
 rtl/vector_load_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vector_load_unit.sv
// Vector load unit: gathers LANES sequential memory words into one vector
// and writes it to the vector register file in a single cycle.
`timescale 1ns/1ps
module vector_load_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LANES   = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned VREG_AW = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [VREG_AW-1:0]      dest,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_rvalid,
    output logic                    VwrEn,
    output logic [VREG_AW-1:0]      VwrAddr,
    output logic [DATA_W*LANES-1:0] Vwrdata
);
    localparam int unsigned VEC_W = DATA_W * LANES;
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
    localparam logic [CNT_W-1:0] ALL_LANES = CNT_W'(LANES);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   issue_q, issue_d;
    logic [CNT_W-1:0]   recv_q, recv_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [VREG_AW-1:0] dest_q, dest_d;
    logic [VEC_W-1:0]   buf_q, buf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wr_en_q, wr_en_d;
    logic [VREG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [VEC_W-1:0]   wr_data_q, wr_data_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        recv_d    = recv_q;
        base_d    = base_q;
        dest_d    = dest_q;
        buf_d     = buf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    dest_d  = dest;
                    issue_d = CNT_W'(1);
                    recv_d  = '0;
                    rd_en_d = 1'b1;
                    addr_d  = base_addr;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (issue_q < ALL_LANES) begin
                    rd_en_d = 1'b1;
                    addr_d  = base_q + ADDR_W'(issue_q);
                    issue_d = issue_q + CNT_W'(1);
                end
                // Responses arrive in request order, so recv_q is the lane index
                if (mem_rvalid && (recv_q < ALL_LANES)) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (recv_q == CNT_W'(i)) begin
                            buf_d[i*DATA_W +: DATA_W] = mem_rdata;
                        end
                    end
                    recv_d = recv_q + CNT_W'(1);
                    if (recv_q == LAST_LANE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = dest_q;
                        wr_data_d = buf_d;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            issue_q   <= '0;
            recv_q    <= '0;
            base_q    <= '0;
            dest_q    <= '0;
            buf_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            recv_q    <= recv_d;
            base_q    <= base_d;
            dest_q    <= dest_d;
            buf_q     <= buf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign VwrEn     = wr_en_q;
    assign VwrAddr   = wr_addr_q;
    assign Vwrdata   = wr_data_q;

endmodule
